uart_rx_vote: RTL and testbench

- UART 8N1 receiver: LSB-first, one start bit, eight data bits, one stop bit.
- Pairs with the existing UART transmitter and feeds the FIFO control FSM through its op_data/op_flag input.
- Adds a 2-FF input synchronizer, start-bit validation, 3-sample majority voting per bit, and framing-error/break handling.

---
 rtl/uart_rx_vote.sv | 148 ++++++++++++++
 tb/tb_uart_rx_vote.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_vote.sv
// UART 8N1 receiver with a 2-FF synchronizer, start-bit validation,
// 3-sample majority voting per bit and framing-error / break handling.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | line idle, waiting for a falling edge on rx_s
// START    | validating the start bit; a voted 1 at mid-bit is a false start
// DATA     | shifting in eight data bits, LSB first
// STOP     | sampling the stop bit; result decided at MID+1
// BRK_WAIT | stop bit was low; hold here until the line returns high
module uart_rx_vote #(
    parameter logic [23:0] baud_cnt_max = 24'd5207
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] op_data,
    output logic       op_flag,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [23:0] MID = baud_cnt_max >> 1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] START    = 3'd1;
    localparam logic [2:0] DATA     = 3'd2;
    localparam logic [2:0] STOP     = 3'd3;
    localparam logic [2:0] BRK_WAIT = 3'd4;

    logic        rx_meta;
    logic        rx_s;
    logic        rx_prev;
    logic [2:0]  state;
    logic [23:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        samp_a;
    logic        samp_b;

    logic        fall;
    logic        at_wrap;
    logic        at_vote;
    logic        vote;

    assign fall    = rx_prev & ~rx_s;
    assign at_wrap = (baud_cnt == baud_cnt_max);
    assign at_vote = (baud_cnt == MID + 24'd1);
    // third sample is the live rx_s in the MID+1 cycle, so the vote resolves there
    assign vote    = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
    assign busy    = (state != IDLE);

    // Synchronizer and edge-history flops reset high so reset looks like an idle line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_a <= 1'b0;
            samp_b <= 1'b0;
        end else begin
            if (baud_cnt == MID - 24'd1) samp_a <= rx_s;
            if (baud_cnt == MID)         samp_b <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= 24'd0;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            op_data   <= 8'h00;
            op_flag   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            op_flag   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall) begin
                        state    <= START;
                        baud_cnt <= 24'd0;
                        bit_cnt  <= 3'd0;
                    end
                end
                START: begin
                    if (at_vote && vote) begin
                        state    <= IDLE;
                        baud_cnt <= 24'd0;
                    end else if (at_wrap) begin
                        state    <= DATA;
                        baud_cnt <= 24'd0;
                        bit_cnt  <= 3'd0;
                    end else begin
                        baud_cnt <= baud_cnt + 24'd1;
                    end
                end
                DATA: begin
                    if (at_vote) shift <= {vote, shift[7:1]};
                    if (at_wrap) begin
                        baud_cnt <= 24'd0;
                        if (bit_cnt == 3'd7) begin
                            state   <= STOP;
                            bit_cnt <= 3'd0;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 24'd1;
                    end
                end
                STOP: begin
                    // Leave at mid stop bit so a start bit right after it is caught.
                    if (at_vote) begin
                        baud_cnt <= 24'd0;
                        if (vote) begin
                            op_data <= shift;
                            op_flag <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BRK_WAIT;
                        end
                    end else if (at_wrap) begin
                        baud_cnt <= 24'd0;
                    end else begin
                        baud_cnt <= baud_cnt + 24'd1;
                    end
                end
                BRK_WAIT: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_vote.sv
// Self-checking bench for uart_rx_vote: directed frames plus randomized
// back-to-back traffic compared against a byte-level expected queue.
module tb_uart_rx_vote;

    localparam logic [23:0] BCM = 24'd31;
    localparam int N   = 32;
    localparam int MID = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] op_data;
    logic       op_flag;
    logic       frame_err;
    logic       busy;

    uart_rx_vote #(.baud_cnt_max(BCM)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .op_data  (op_data),
        .op_flag  (op_flag),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int flag_cnt = 0;
    int ferr_cnt = 0;
    int overlap_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (op_flag) begin
                flag_cnt++;
                got_q.push_back(op_data);
            end
            if (frame_err) ferr_cnt++;
            if (op_flag && frame_err) overlap_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serialize start + nbits data bits (LSB first); a full frame also sends the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_val,
                              input int glitch_bit, input int nbits);
        rx = 1'b0;
        cyc(N);
        for (int i = 0; i < nbits; i++) begin
            rx = b[i];
            if (i == glitch_bit) begin
                cyc(MID);
                rx = ~b[i];
                cyc(1);
                rx = b[i];
                cyc(N - MID - 1);
            end else begin
                cyc(N);
            end
        end
        if (nbits == 8) begin
            rx = stop_val;
            cyc(N);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, e0, lat, edges, gap;
        bit seen;
        logic [7:0] b;

        cyc(3);
        chk("rst_op_data", 32'(op_data), 32'h00);
        chk("rst_op_flag", 32'(op_flag), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        cyc(2 * N);

        // 0x55 with end-to-end latency measurement
        f0 = flag_cnt; e0 = ferr_cnt;
        lat = 0; seen = 1'b0;
        exp_q.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1, -1, 8);
            begin
                for (int k = 1; k <= 400 && !seen; k++) begin
                    @(negedge clk);
                    if (op_flag) begin
                        seen = 1'b1;
                        lat  = k;
                    end
                end
            end
        join
        edges = lat - 1;
        chk("lat_seen", 32'(seen), 32'h1);
        chk("lat_window", 32'((edges >= 2 + 9 * N + MID + 1) && (edges <= 2 + 9 * N + MID + 3)), 32'h1);
        cyc(N);
        chk("d55_flags", 32'(flag_cnt - f0), 32'd1);
        chk("d55_data", 32'(op_data), 32'h55);
        chk("d55_ferr", 32'(ferr_cnt - e0), 32'd0);

        // short low glitch in IDLE: false start rejected at MID+1
        f0 = flag_cnt; e0 = ferr_cnt;
        rx = 1'b0;
        cyc(6);
        rx = 1'b1;
        cyc(MID - 6);
        chk("glitch_busy_mid", 32'(busy), 32'h1);
        cyc(8);
        chk("glitch_busy_done", 32'(busy), 32'h0);
        cyc(N);
        chk("glitch_flags", 32'(flag_cnt - f0), 32'd0);
        chk("glitch_ferr", 32'(ferr_cnt - e0), 32'd0);

        // 0xA3 with a one-clock inverted glitch at the middle of bit 2
        f0 = flag_cnt;
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1, 2, 8);
        cyc(N);
        chk("vote_flags", 32'(flag_cnt - f0), 32'd1);
        chk("vote_data", 32'(op_data), 32'hA3);

        // 0x3C with low stop bit and line held low: one frame_err, then break wait
        f0 = flag_cnt; e0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, -1, 8);
        cyc(3 * N);
        chk("ferr_pulses", 32'(ferr_cnt - e0), 32'd1);
        chk("ferr_flags", 32'(flag_cnt - f0), 32'd0);
        chk("ferr_data_kept", 32'(op_data), 32'hA3);
        chk("ferr_busy_held", 32'(busy), 32'h1);
        rx = 1'b1;
        cyc(5);
        chk("ferr_busy_release", 32'(busy), 32'h0);
        cyc(2 * N);

        // back-to-back 0x00 then 0xFF
        f0 = flag_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, -1, 8);
        send_frame(8'hFF, 1'b1, -1, 8);
        cyc(N);
        chk("b2b_flags", 32'(flag_cnt - f0), 32'd2);
        chk("b2b_data", 32'(op_data), 32'hFF);

        // reset during data bit 4 of 0x81, then a clean 0x7E
        f0 = flag_cnt;
        send_frame(8'h81, 1'b1, -1, 4);
        rx = 1'b0;
        cyc(MID);
        rst_n = 1'b0;
        cyc(3);
        chk("mrst_op_data", 32'(op_data), 32'h00);
        chk("mrst_op_flag", 32'(op_flag), 32'h0);
        chk("mrst_frame_err", 32'(frame_err), 32'h0);
        chk("mrst_busy", 32'(busy), 32'h0);
        rx = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        cyc(2 * N);
        chk("mrst_no_flag", 32'(flag_cnt - f0), 32'd0);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, -1, 8);
        cyc(N);
        chk("mrst_data", 32'(op_data), 32'h7E);

        // randomized traffic with random idle gaps (including zero)
        for (int i = 0; i < 30; i++) begin
            b   = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, 40);
            exp_q.push_back(b);
            send_frame(b, 1'b1, -1, 8);
            cyc(MID);
            chk("rand_data", 32'(op_data), 32'(b));
            rx = 1'b1;
            if (gap > 0) cyc(gap);
        end
        cyc(2 * N);

        chk("total_bytes", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("byte_stream", 32'(got_q[i]), 32'(exp_q[i]));
        chk("total_ferr", 32'(ferr_cnt), 32'd1);
        chk("flag_ferr_overlap", 32'(overlap_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
